ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- WIDTH-bit unsigned adder built as a chain of 1-bit full adders. The carry ripples combinationally from LSB to MSB.
- Sum and carry-out are captured in an output register, so results appear one clock after the operands.
- Serves as the datapath's basic adder primitive and as a reference against faster adder variants.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a, b and cin are valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry into bit 0
- out_valid  output  1  s and c_out hold a fresh result
- s  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH
- c_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Combinational chain: c[0]=cin; for each bit i, sum_i=a[i]^b[i]^c[i] and c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])). The chain has no lookahead or prefix logic.
- The arithmetic identity is {c_out,s} = a + b + cin, computed exactly at WIDTH+1 bits.
- Latency is 1 cycle. If in_valid=1 at edge k, then at edge k: s and c_out load the chain result and out_valid is set to 1.
- If in_valid=0 at an edge: s and c_out hold their previous values and out_valid goes to 0.
- Throughput is one operation per cycle. There is no backpressure and no handshake beyond the valid flag.
- Reset: when rst_n=0, s=0, c_out=0 and out_valid=0 immediately, independent of clk. The first capture happens on the first rising edge after rst_n deasserts.
- Reset asserted mid-stream discards the in-flight result, and no out_valid pulse is produced for it.
- Boundaries:
  - all-ones + all-ones + 1 gives s=all-ones, c_out=1.
  - all-ones + 0 + 1 gives s=0, c_out=1 (full carry propagation across WIDTH bits).
  - 0+0+0 gives s=0, c_out=0.
- X on inputs while in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro RCA_OVERFLOW_EN.
- When defined, add output port ovf (1 bit, registered alongside s). ovf = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow flag. It resets to 0 and holds when in_valid=0.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: the default WIDTH constant RCA_WIDTH_DEFAULT=4. No typedefs are needed.
- One sub-module, full_adder, with inputs x, y, ci and outputs sum, co. It is instantiated WIDTH times via a generate loop.
- Output registers live in the top.

Test Plan (WIDTH=4; each vector driven with in_valid=1, checked one cycle later):
- a=0011, b=1100, cin=0 -> s=1111, c_out=0; ovf=0 if enabled.
- a=0000, b=1111, cin=0 -> s=1111, c_out=0. a=0101, b=1100, cin=0 -> s=0001, c_out=1.
- a=1010, b=1101, cin=1 -> s=1000, c_out=1. a=0111, b=1011, cin=1 -> s=0011, c_out=1. a=1000, b=1001, cin=1 -> s=0010, c_out=1; ovf=1 if enabled.
- Carry ripple: a=1111, b=0000, cin=1 -> s=0000, c_out=1. Overflow: a=0111, b=0001, cin=0 -> s=1000, c_out=0, ovf=1.
- Valid gating:
  - Back-to-back vectors on consecutive cycles produce results on consecutive cycles.
  - A cycle with in_valid=0 and random a/b gives out_valid=0 with s and c_out unchanged.
- Async reset:
  - Pulse rst_n low between clock edges while out_valid=1 and s=1111 -> s, c_out and out_valid read 0 immediately.
  - After release, the next valid vector is captured normally.
- Exhaustive randomized check: all 512 combinations of a, b and cin compared against a+b+cin. Repeat with WIDTH=1 and WIDTH=16.

Source files
------------

// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Holds the default operand width used by the top-level parameter.
package ripple_carry_adder_pkg;

    localparam int unsigned RCA_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder cell, chained by ripple_carry_adder.
// Ports: x, y, ci in; sum, co out (purely combinational).
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic p;

    assign p   = x ^ y;
    assign sum = p ^ ci;
    assign co  = (x & y) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with a registered result (1-cycle latency).
// Ports: clk, rst_n (async low), in_valid, a, b, cin in;
//        out_valid, s, c_out out; ovf out when RCA_OVERFLOW_EN is defined.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef RCA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .x   (a[i]),
            .y   (b[i]),
            .ci  (carry[i]),
            .sum (sum_w[i]),
            .co  (carry[i+1])
        );
    end

    logic [WIDTH-1:0] s_d, s_q;
    logic             c_out_d, c_out_q;
    logic             out_valid_d, out_valid_q;

    // Result registers only load on a valid cycle, so junk operands
    // presented with in_valid low never reach the outputs.
    always_comb begin
        s_d         = s_q;
        c_out_d     = c_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d     = sum_w;
            c_out_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign c_out     = c_out_q;
    assign out_valid = out_valid_q;

`ifdef RCA_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Signed overflow: carry into the sign bit differs from carry out.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at WIDTH 4, 1 and 16.
// Directed vector table, valid gating, async reset and model-based sweeps.
module tb_ripple_carry_adder;

    logic clk;
    logic rst_n;

    logic        v4, c4, ov4, co4, ovf4;
    logic [3:0]  a4, b4, s4;
    logic        v1, c1, ov1, co1, ovf1;
    logic [0:0]  a1, b1, s1;
    logic        v16, c16, ov16, co16, ovf16;
    logic [15:0] a16, b16, s16;

    int total = 0;
    int bad   = 0;

    ripple_carry_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .out_valid(ov4), .s(s4), .c_out(co4)
`ifdef RCA_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

    ripple_carry_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .s(s1), .c_out(co1)
`ifdef RCA_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    ripple_carry_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
        .out_valid(ov16), .s(s16), .c_out(co16)
`ifdef RCA_OVERFLOW_EN
        , .ovf(ovf16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic longint unsigned ref_sum(int w, longint unsigned a, longint unsigned b, bit ci);
        return a + b + longint'(ci);
    endfunction

    function automatic bit ref_ovf(int w, longint unsigned a, longint unsigned b, bit ci);
        longint sa, sb, r, lo, hi;
        longint half;
        half = longint'(1) << (w - 1);
        sa = (a >= half) ? longint'(a) - 2 * half : longint'(a);
        sb = (b >= half) ? longint'(b) - 2 * half : longint'(b);
        r  = sa + sb + longint'(ci);
        lo = -half;
        hi = half - 1;
        return (r < lo) || (r > hi);
    endfunction

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t tbl [10];

    logic [3:0]  hold_s4;
    logic        hold_co4;
    logic        hold_ovf4;
    logic [15:0] exp_s16;
    logic        exp_co16, exp_ovf16;
    longint unsigned r;

    initial begin
        tbl[0] = '{4'b0011, 4'b1100, 1'b0, 4'b1111, 1'b0, 1'b0};
        tbl[1] = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0};
        tbl[2] = '{4'b0101, 4'b1100, 1'b0, 4'b0001, 1'b1, 1'b0};
        tbl[3] = '{4'b1010, 4'b1101, 1'b1, 4'b1000, 1'b1, 1'b0};
        tbl[4] = '{4'b0111, 4'b1011, 1'b1, 4'b0011, 1'b1, 1'b0};
        tbl[5] = '{4'b1000, 4'b1001, 1'b1, 4'b0010, 1'b1, 1'b1};
        tbl[6] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[7] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[8] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        tbl[9] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        v4 = 0; a4 = '0; b4 = '0; c4 = 0;
        v1 = 0; a1 = '0; b1 = '0; c1 = 0;
        v16 = 0; a16 = '0; b16 = '0; c16 = 0;
        #2;
        chk("rst_ov4", 64'(ov4), 0);
        chk("rst_s4", 64'(s4), 0);
        chk("rst_co4", 64'(co4), 0);
        chk("rst_ov1", 64'(ov1), 0);
        chk("rst_ov16", 64'(ov16), 0);
        chk("rst_s16", 64'(s16), 0);
`ifdef RCA_OVERFLOW_EN
        chk("rst_ovf4", 64'(ovf4), 0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back directed vectors, one per cycle.
        for (int i = 0; i < 10; i++) begin
            v4 = 1; a4 = tbl[i].a; b4 = tbl[i].b; c4 = tbl[i].cin;
            tick();
            chk($sformatf("tbl%0d_ov", i), 64'(ov4), 1);
            chk($sformatf("tbl%0d_s", i), 64'(s4), 64'(tbl[i].s));
            chk($sformatf("tbl%0d_co", i), 64'(co4), 64'(tbl[i].co));
`ifdef RCA_OVERFLOW_EN
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf4), 64'(tbl[i].ovf));
`endif
        end

        // Load a known result, then idle with random operands.
        v4 = 1; a4 = 4'b1000; b4 = 4'b1001; c4 = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            v4 = 0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            tick();
            chk("idle_ov", 64'(ov4), 0);
            chk("idle_s", 64'(s4), 64'h2);
            chk("idle_co", 64'(co4), 1);
`ifdef RCA_OVERFLOW_EN
            chk("idle_ovf", 64'(ovf4), 1);
`endif
        end

        // Async reset between edges while holding a fresh 1111 result.
        v4 = 1; a4 = 4'b1111; b4 = 4'b0000; c4 = 0;
        tick();
        chk("pre_rst_ov", 64'(ov4), 1);
        chk("pre_rst_s", 64'(s4), 64'hf);
        v4 = 1; a4 = 4'b0110; b4 = 4'b0011; c4 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_ov", 64'(ov4), 0);
        chk("async_s", 64'(s4), 0);
        chk("async_co", 64'(co4), 0);
        @(posedge clk);
        #1;
        chk("in_rst_ov", 64'(ov4), 0);
        #1 rst_n = 1'b1;
        v4 = 1; a4 = 4'b1110; b4 = 4'b0011; c4 = 1;
        tick();
        chk("post_rst_ov", 64'(ov4), 1);
        chk("post_rst_s", 64'(s4), 64'h2);
        chk("post_rst_co", 64'(co4), 1);

        // Exhaustive WIDTH=4 / WIDTH=1 plus random WIDTH=16 with gaps.
        exp_s16 = '0; exp_co16 = 0; exp_ovf16 = 0;
        for (int i = 0; i < 512; i++) begin
            v4 = 1; a4 = i[3:0]; b4 = i[7:4]; c4 = i[8];
            v1 = 1; a1 = i[0]; b1 = i[1]; c1 = i[2];
            v16 = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            if (i == 0) begin v16 = 1; a16 = 16'hffff; b16 = 16'hffff; c16 = 1; end
            if (i == 1) begin v16 = 1; a16 = 16'hffff; b16 = 16'h0000; c16 = 1; end
            if (i == 2) begin v16 = 1; a16 = 16'h0000; b16 = 16'h0000; c16 = 0; end
            if (v16) begin
                r = ref_sum(16, 64'(a16), 64'(b16), c16);
                exp_s16   = r[15:0];
                exp_co16  = r[16];
                exp_ovf16 = ref_ovf(16, 64'(a16), 64'(b16), c16);
            end
            tick();
            r = ref_sum(4, 64'(a4), 64'(b4), c4);
            chk("ex4_ov", 64'(ov4), 1);
            chk("ex4_s", 64'(s4), 64'(r[3:0]));
            chk("ex4_co", 64'(co4), 64'(r[4]));
            r = ref_sum(1, 64'(a1), 64'(b1), c1);
            chk("ex1_ov", 64'(ov1), 1);
            chk("ex1_s", 64'(s1), 64'(r[0]));
            chk("ex1_co", 64'(co1), 64'(r[1]));
            chk("r16_ov", 64'(ov16), 64'(v16));
            chk("r16_s", 64'(s16), 64'(exp_s16));
            chk("r16_co", 64'(co16), 64'(exp_co16));
`ifdef RCA_OVERFLOW_EN
            chk("ex4_ovf", 64'(ovf4), 64'(ref_ovf(4, 64'(a4), 64'(b4), c4)));
            chk("ex1_ovf", 64'(ovf1), 64'(ref_ovf(1, 64'(a1), 64'(b1), c1)));
            chk("r16_ovf", 64'(ovf16), 64'(exp_ovf16));
`endif
        end

        // Idle after the sweep: all three hold, valid drops.
        hold_s4 = s4; hold_co4 = co4; hold_ovf4 = ovf4;
        r = ref_sum(4, 64'hf, 64'hf, 1'b1);
        v4 = 0; v1 = 0; v16 = 0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        tick();
        chk("end_ov4", 64'(ov4), 0);
        chk("end_s4", 64'(s4), 64'(r[3:0]));
        chk("end_co4", 64'(co4), 64'(r[4]));
        chk("end_ov1", 64'(ov1), 0);
        chk("end_ov16", 64'(ov16), 0);
        chk("end_s16", 64'(s16), 64'(exp_s16));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
